// File: rtl/procyon_bitmap2binary_serializer_if.sv
// rtl/procyon_bitmap2binary_serializer_if.sv - bitmap-in / index-out handshake bundle for the bitmap serializer
// Optional o_remaining member present when PROCYON_BITMAP_SERIALIZER_COUNT_EN is defined.
interface procyon_bitmap2binary_serializer_if #(
    parameter int OPTN_VECTOR_WIDTH = 8
);
    localparam int BINARY_WIDTH = (OPTN_VECTOR_WIDTH == 1) ? 1 : $clog2(OPTN_VECTOR_WIDTH);

    logic                         i_valid;
    logic                         o_ready;
    logic [OPTN_VECTOR_WIDTH-1:0] i_vector;
    logic                         o_valid;
    logic                         i_ready;
    logic [BINARY_WIDTH-1:0]      o_binary;
    logic                         o_last;
`ifdef PROCYON_BITMAP_SERIALIZER_COUNT_EN
    logic [BINARY_WIDTH:0]        o_remaining;

    modport slave (
        input  i_valid, i_vector, i_ready,
        output o_ready, o_valid, o_binary, o_last, o_remaining
    );
    modport master (
        output i_valid, i_vector, i_ready,
        input  o_ready, o_valid, o_binary, o_last, o_remaining
    );
`else
    modport slave (
        input  i_valid, i_vector, i_ready,
        output o_ready, o_valid, o_binary, o_last
    );
    modport master (
        output i_valid, i_vector, i_ready,
        input  o_ready, o_valid, o_binary, o_last
    );
`endif
endinterface

// File: rtl/procyon_bitmap2binary_serializer.sv
// rtl/procyon_bitmap2binary_serializer.sv - serializes a latched bitmap into set-bit indices, lowest first
// Optional popcount output o_remaining guarded by PROCYON_BITMAP_SERIALIZER_COUNT_EN.
module procyon_bitmap2binary_serializer #(
    parameter int OPTN_VECTOR_WIDTH = 8
) (
    input logic                               clk,
    input logic                               n_rst,
    procyon_bitmap2binary_serializer_if.slave bus
);
    localparam int BINARY_WIDTH = (OPTN_VECTOR_WIDTH == 1) ? 1 : $clog2(OPTN_VECTOR_WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic [OPTN_VECTOR_WIDTH-1:0] pending_q, pending_d;
    logic [OPTN_VECTOR_WIDTH-1:0] pending_lsb_cleared;
    logic [BINARY_WIDTH-1:0]      enc;
    logic                         single_bit;
    logic                         draining;

    assign draining = (state_q == DRAIN);

    // Scan high to low so the last hit, the lowest set bit, wins.
    always_comb begin
        enc = '0;
        for (int i = OPTN_VECTOR_WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc = BINARY_WIDTH'(i);
            end
        end
    end

    assign pending_lsb_cleared = pending_q & (pending_q - OPTN_VECTOR_WIDTH'(1));
    assign single_bit          = (pending_q != '0) && (pending_lsb_cleared == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (!draining) begin
            if (bus.i_valid) begin
                pending_d = bus.i_vector;
                state_d   = (bus.i_vector != '0) ? DRAIN : IDLE;
            end
        end else if (bus.i_ready) begin
            pending_d = pending_lsb_cleared;
            if (single_bit) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign bus.o_ready  = !draining;
    assign bus.o_valid  = draining;
    assign bus.o_binary = draining ? enc : '0;
    assign bus.o_last   = draining && single_bit;

`ifdef PROCYON_BITMAP_SERIALIZER_COUNT_EN
    localparam int COUNT_WIDTH = BINARY_WIDTH + 1;

    logic [COUNT_WIDTH-1:0] popcount;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < OPTN_VECTOR_WIDTH; i++) begin
            popcount = popcount + COUNT_WIDTH'(pending_q[i]);
        end
    end

    assign bus.o_remaining = draining ? popcount : '0;
`endif
endmodule
